execute_stage_md: RTL and testbench
===================================

EXECUTE_STAGE_MD -- requirements
Module: execute_stage_md

Interface
REQ-001 Parameter DATA_WIDTH, default 32, datapath width (even, >=8).
REQ-002 Parameter ADDR_WIDTH, default 10, PC width.
REQ-003 i_clk  in  1  clock; all state updates on rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 i_rs1_data_e, i_rs2_data_e, i_immext_e  in  DATA_WIDTH each  ID/EX operands, immediate.
REQ-006 i_pc_e, i_pc4_e  in  ADDR_WIDTH each  current PC, PC+4.
REQ-007 i_rd_addr_e  in  5  destination register.
REQ-008 i_aluctrl_e  in  alu_op_t  single-cycle ALU operation.
REQ-009 i_alusrc_e  in  2  [0]=1 selects immediate for B; [1]=1 selects PC for A.
REQ-010 i_regwrite_e, i_memwrite_e  in  1 each  write enables.
REQ-011 i_resultsrc_e  in  2  result source select; i_f3_e  in  3  funct3.
REQ-012 i_md_valid_e  in  1  EX instruction is an M-extension op.
REQ-013 i_md_op_e  in  3  M funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU.
REQ-014 i_forward_m, i_forward_w  in  DATA_WIDTH each  MEM/WB forwarded data.
REQ-015 i_forward_a, i_forward_b  in  2 each  0 regfile, 1 WB, 2 MEM, 3 treated as 0.
REQ-016 i_flush_e  in  1  kill the EX instruction.
REQ-017 o_pctarget_e  out  ADDR_WIDTH  i_pc_e + i_immext_e truncated, combinational.
REQ-018 o_zero_e  out  1  ALU zero flag, combinational.
REQ-019 o_stall_e  out  1  combinational request to hold IF/ID/EX.
REQ-020 o_alu_result_m, o_write_data_m  out  DATA_WIDTH each  registered result, store data.
REQ-021 o_regwrite_m, o_memwrite_m  out  1 each; o_resultsrc_m  out  2; o_rd_addr_m  out  5; o_pc4_m  out  ADDR_WIDTH; o_f3_m  out  3  registered pass-throughs.

Function
REQ-022 Forwarded operands, operand-A/B muxing and ALU behaviour SHALL be identical to the single-cycle execute path for i_md_valid_e=0, latency 1 cycle to EX/MEM.
REQ-023 M-unit FSM SHALL have states IDLE, BUSY, DONE.
REQ-024 IDLE with i_md_valid_e=1 and i_flush_e=0 (cycle T): o_stall_e=1, forwarded rs1/rs2, op, rd and controls captured, go BUSY.
REQ-025 BUSY SHALL run exactly DATA_WIDTH iterations (radix-2 shift-add multiply / restoring divide on magnitudes), o_stall_e=1, then go DONE.
REQ-026 DONE (cycle T+DATA_WIDTH+1): o_stall_e=0, EX/MEM loads M result with captured rd/controls, go IDLE; total stall = DATA_WIDTH+1 cycles.
REQ-027 While o_stall_e=1 EX/MEM SHALL load a bubble: o_regwrite_m=0, o_memwrite_m=0, other fields held.
REQ-028 MUL returns low DATA_WIDTH bits; MULH/MULHSU/MULHU return high bits of signed x signed, signed x unsigned, unsigned x unsigned 2*DATA_WIDTH product.
REQ-029 Divide by zero: DIV/DIVU quotient all ones, REM/REMU = dividend; same latency.
REQ-030 Signed overflow (most-negative / -1): DIV = most-negative, REM = 0; same latency.
REQ-031 Signed quotient negative iff operand signs differ and divisor nonzero; remainder takes dividend sign.
REQ-032 i_flush_e=1 in BUSY or DONE: return IDLE next edge, no result, o_stall_e=0 from the cycle after; flush in IDLE with M op: not started.
REQ-033 Forwarding input changes after cycle T SHALL NOT affect the M result.
REQ-034 A new M op SHALL be accepted only in IDLE.

Reset
REQ-035 Asynchronous reset SHALL force IDLE, iteration counter 0, o_stall_e=0, all EX/MEM outputs 0 except o_f3_m=3'b010, including mid-operation.

Verification
REQ-036 MUL rs1=7, rs2=0xFFFFFFFD -> stall 33 cycles, then o_alu_result_m=0xFFFFFFEB, o_regwrite_m=1.
REQ-037 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-038 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0x00000000.
REQ-039 DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 0x00000064; latency 33.
REQ-040 Flush at 10th BUSY cycle -> o_stall_e=0 next cycle, no o_regwrite_m pulse; reset asserted mid-BUSY -> IDLE, o_f3_m=3'b010.
REQ-041 ADD with i_forward_a=2, i_forward_m=5, rs2=3 -> o_alu_result_m=8 after 1 cycle, o_stall_e=0.

Source files
------------

// File: rtl/execute_stage_md.sv
// Execute stage with an iterative M-extension unit.
// Plain ALU ops complete in one cycle into EX/MEM. M ops run a radix-2
// shift-add multiply or restoring divide on operand magnitudes and hold
// the front of the pipeline until the result is ready.
module execute_stage_md #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_rs1_data_e,
  input  logic [DATA_WIDTH-1:0] i_rs2_data_e,
  input  logic [DATA_WIDTH-1:0] i_immext_e,
  input  logic [ADDR_WIDTH-1:0] i_pc_e,
  input  logic [ADDR_WIDTH-1:0] i_pc4_e,
  input  logic [4:0]            i_rd_addr_e,
  input  logic [3:0]            i_aluctrl_e,
  input  logic [1:0]            i_alusrc_e,
  input  logic                  i_regwrite_e,
  input  logic                  i_memwrite_e,
  input  logic [1:0]            i_resultsrc_e,
  input  logic [2:0]            i_f3_e,
  input  logic                  i_md_valid_e,
  input  logic [2:0]            i_md_op_e,
  input  logic [DATA_WIDTH-1:0] i_forward_m,
  input  logic [DATA_WIDTH-1:0] i_forward_w,
  input  logic [1:0]            i_forward_a,
  input  logic [1:0]            i_forward_b,
  input  logic                  i_flush_e,
  output logic [ADDR_WIDTH-1:0] o_pctarget_e,
  output logic                  o_zero_e,
  output logic                  o_stall_e,
  output logic [DATA_WIDTH-1:0] o_alu_result_m,
  output logic [DATA_WIDTH-1:0] o_write_data_m,
  output logic                  o_regwrite_m,
  output logic                  o_memwrite_m,
  output logic [1:0]            o_resultsrc_m,
  output logic [4:0]            o_rd_addr_m,
  output logic [ADDR_WIDTH-1:0] o_pc4_m,
  output logic [2:0]            o_f3_m
);

  localparam int SHW  = $clog2(DATA_WIDTH);
  localparam int CNTW = $clog2(DATA_WIDTH + 1);
  localparam logic [CNTW-1:0] LAST_ITER = CNTW'(DATA_WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_PASB = 4'd10;

  // Two's-complement negate when the flag is set (magnitude / sign restore).
  function automatic logic [DATA_WIDTH-1:0] neg_if(input logic [DATA_WIDTH-1:0] v,
                                                   input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*DATA_WIDTH-1:0] neg2_if(input logic [2*DATA_WIDTH-1:0] v,
                                                      input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // Final M result from the iteration registers and the captured sign flags.
  function automatic logic [DATA_WIDTH-1:0] md_result(input logic [2:0] op,
                                                      input logic [DATA_WIDTH-1:0] hi,
                                                      input logic [DATA_WIDTH-1:0] lo,
                                                      input logic pneg,
                                                      input logic qneg,
                                                      input logic rneg);
    logic [2*DATA_WIDTH-1:0] prod;
    prod = neg2_if({hi, lo}, pneg);
    case (op)
      3'd0:               return prod[DATA_WIDTH-1:0];
      3'd1, 3'd2, 3'd3:   return prod[2*DATA_WIDTH-1:DATA_WIDTH];
      3'd4, 3'd5:         return neg_if(lo, qneg);
      default:            return neg_if(hi, rneg);
    endcase
  endfunction

  logic [1:0]            r_state;
  logic [CNTW-1:0]       r_cnt;
  logic [DATA_WIDTH-1:0] r_hi, r_lo, r_b, r_wdata;
  logic                  r_pneg, r_qneg, r_rneg;
  logic [2:0]            r_md_op, r_f3;
  logic [4:0]            r_rd;
  logic                  r_regwrite, r_memwrite;
  logic [1:0]            r_resultsrc;
  logic [ADDR_WIDTH-1:0] r_pc4;

  logic [DATA_WIDTH-1:0] w_fwd_a, w_fwd_b, w_src_a, w_src_b, w_alu;
  logic [SHW-1:0]        w_shamt;
  logic                  w_start, w_a_signed, w_b_signed, w_sa, w_sb;
  logic [DATA_WIDTH:0]   w_mul_sum, w_div_shift, w_div_diff;
  logic                  w_div_ge;

  // Forwarding muxes: code 3 behaves like the register file path.
  always_comb begin
    case (i_forward_a)
      2'd1:    w_fwd_a = i_forward_w;
      2'd2:    w_fwd_a = i_forward_m;
      default: w_fwd_a = i_rs1_data_e;
    endcase
    case (i_forward_b)
      2'd1:    w_fwd_b = i_forward_w;
      2'd2:    w_fwd_b = i_forward_m;
      default: w_fwd_b = i_rs2_data_e;
    endcase
  end

  assign w_src_a = i_alusrc_e[1] ? DATA_WIDTH'(i_pc_e) : w_fwd_a;
  assign w_src_b = i_alusrc_e[0] ? i_immext_e : w_fwd_b;
  assign w_shamt = w_src_b[SHW-1:0];

  // Single-cycle ALU.
  always_comb begin
    w_alu = '0;
    case (i_aluctrl_e)
      ALU_ADD:  w_alu = w_src_a + w_src_b;
      ALU_SUB:  w_alu = w_src_a - w_src_b;
      ALU_AND:  w_alu = w_src_a & w_src_b;
      ALU_OR:   w_alu = w_src_a | w_src_b;
      ALU_XOR:  w_alu = w_src_a ^ w_src_b;
      ALU_SLT:  w_alu = DATA_WIDTH'($signed(w_src_a) < $signed(w_src_b));
      ALU_SLTU: w_alu = DATA_WIDTH'(w_src_a < w_src_b);
      ALU_SLL:  w_alu = w_src_a << w_shamt;
      ALU_SRL:  w_alu = w_src_a >> w_shamt;
      ALU_SRA:  w_alu = $signed(w_src_a) >>> w_shamt;
      ALU_PASB: w_alu = w_src_b;
      default:  w_alu = '0;
    endcase
  end

  assign o_zero_e     = (w_alu == '0);
  assign o_pctarget_e = i_pc_e + ADDR_WIDTH'(i_immext_e);

  // Operand signedness: MUL/MULH/DIV/REM treat both as signed, MULHSU only rs1.
  assign w_a_signed = (i_md_op_e == 3'd0) || (i_md_op_e == 3'd1) || (i_md_op_e == 3'd2) ||
                      (i_md_op_e == 3'd4) || (i_md_op_e == 3'd6);
  assign w_b_signed = (i_md_op_e == 3'd0) || (i_md_op_e == 3'd1) ||
                      (i_md_op_e == 3'd4) || (i_md_op_e == 3'd6);
  assign w_sa = w_a_signed & w_fwd_a[DATA_WIDTH-1];
  assign w_sb = w_b_signed & w_fwd_b[DATA_WIDTH-1];

  assign w_start   = (r_state == S_IDLE) && i_md_valid_e && !i_flush_e;
  assign o_stall_e = i_rst_n && (w_start || (r_state == S_BUSY));

  // One iteration step: multiply adds the multiplicand on lo[0], divide
  // shifts in the next dividend bit and subtracts when it fits. A zero
  // divisor always "fits", giving an all-ones quotient and the dividend
  // as remainder without a special case.
  assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_div_shift = {r_hi, r_lo[DATA_WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_b};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_b});

  // M-unit control: IDLE -> BUSY for DATA_WIDTH iterations -> DONE -> IDLE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_start) r_state <= S_BUSY;
        end
        S_BUSY: begin
          if (i_flush_e) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == LAST_ITER) begin
            r_state <= S_DONE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // M-unit datapath: operand capture at start, then one iteration per BUSY cycle.
  always_ff @(posedge i_clk) begin
    if (w_start) begin
      r_hi        <= '0;
      r_lo        <= neg_if(w_fwd_a, w_sa);
      r_b         <= neg_if(w_fwd_b, w_sb);
      r_pneg      <= w_sa ^ w_sb;
      r_qneg      <= (w_sa ^ w_sb) && (w_fwd_b != '0);
      r_rneg      <= w_sa;
      r_md_op     <= i_md_op_e;
      r_wdata     <= w_fwd_b;
      r_rd        <= i_rd_addr_e;
      r_regwrite  <= i_regwrite_e;
      r_memwrite  <= i_memwrite_e;
      r_resultsrc <= i_resultsrc_e;
      r_pc4       <= i_pc4_e;
      r_f3        <= i_f3_e;
    end else if (r_state == S_BUSY) begin
      if (r_md_op[2]) begin
        r_hi <= w_div_ge ? w_div_diff[DATA_WIDTH-1:0] : w_div_shift[DATA_WIDTH-1:0];
        r_lo <= {r_lo[DATA_WIDTH-2:0], w_div_ge};
      end else begin
        r_hi <= w_mul_sum[DATA_WIDTH:1];
        r_lo <= {w_mul_sum[0], r_lo[DATA_WIDTH-1:1]};
      end
    end
  end

  // EX/MEM register: bubble on flush or stall, M result in DONE, ALU otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_alu_result_m <= '0;
      o_write_data_m <= '0;
      o_regwrite_m   <= 1'b0;
      o_memwrite_m   <= 1'b0;
      o_resultsrc_m  <= 2'b00;
      o_rd_addr_m    <= 5'd0;
      o_pc4_m        <= '0;
      o_f3_m         <= 3'b010;
    end else if (i_flush_e || o_stall_e) begin
      o_regwrite_m <= 1'b0;
      o_memwrite_m <= 1'b0;
    end else if (r_state == S_DONE) begin
      o_alu_result_m <= md_result(r_md_op, r_hi, r_lo, r_pneg, r_qneg, r_rneg);
      o_write_data_m <= r_wdata;
      o_regwrite_m   <= r_regwrite;
      o_memwrite_m   <= r_memwrite;
      o_resultsrc_m  <= r_resultsrc;
      o_rd_addr_m    <= r_rd;
      o_pc4_m        <= r_pc4;
      o_f3_m         <= r_f3;
    end else begin
      o_alu_result_m <= w_alu;
      o_write_data_m <= w_fwd_b;
      o_regwrite_m   <= i_regwrite_e;
      o_memwrite_m   <= i_memwrite_e;
      o_resultsrc_m  <= i_resultsrc_e;
      o_rd_addr_m    <= i_rd_addr_e;
      o_pc4_m        <= i_pc4_e;
      o_f3_m         <= i_f3_e;
    end
  end

endmodule

// File: tb/tb_execute_stage_md.sv
// Bench for execute_stage_md: directed vectors, scoreboard queue of
// expected write-backs drained by a monitor on o_regwrite_m.
module tb_execute_stage_md;
  localparam int DW = 32;
  localparam int AW = 10;

  logic          i_clk, i_rst_n;
  logic [DW-1:0] i_rs1_data_e, i_rs2_data_e, i_immext_e;
  logic [AW-1:0] i_pc_e, i_pc4_e;
  logic [4:0]    i_rd_addr_e;
  logic [3:0]    i_aluctrl_e;
  logic [1:0]    i_alusrc_e;
  logic          i_regwrite_e, i_memwrite_e;
  logic [1:0]    i_resultsrc_e;
  logic [2:0]    i_f3_e;
  logic          i_md_valid_e;
  logic [2:0]    i_md_op_e;
  logic [DW-1:0] i_forward_m, i_forward_w;
  logic [1:0]    i_forward_a, i_forward_b;
  logic          i_flush_e;
  logic [AW-1:0] o_pctarget_e;
  logic          o_zero_e, o_stall_e;
  logic [DW-1:0] o_alu_result_m, o_write_data_m;
  logic          o_regwrite_m, o_memwrite_m;
  logic [1:0]    o_resultsrc_m;
  logic [4:0]    o_rd_addr_m;
  logic [AW-1:0] o_pc4_m;
  logic [2:0]    o_f3_m;

  execute_stage_md #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_rs1_data_e(i_rs1_data_e), .i_rs2_data_e(i_rs2_data_e), .i_immext_e(i_immext_e),
    .i_pc_e(i_pc_e), .i_pc4_e(i_pc4_e), .i_rd_addr_e(i_rd_addr_e),
    .i_aluctrl_e(i_aluctrl_e), .i_alusrc_e(i_alusrc_e),
    .i_regwrite_e(i_regwrite_e), .i_memwrite_e(i_memwrite_e),
    .i_resultsrc_e(i_resultsrc_e), .i_f3_e(i_f3_e),
    .i_md_valid_e(i_md_valid_e), .i_md_op_e(i_md_op_e),
    .i_forward_m(i_forward_m), .i_forward_w(i_forward_w),
    .i_forward_a(i_forward_a), .i_forward_b(i_forward_b),
    .i_flush_e(i_flush_e),
    .o_pctarget_e(o_pctarget_e), .o_zero_e(o_zero_e), .o_stall_e(o_stall_e),
    .o_alu_result_m(o_alu_result_m), .o_write_data_m(o_write_data_m),
    .o_regwrite_m(o_regwrite_m), .o_memwrite_m(o_memwrite_m),
    .o_resultsrc_m(o_resultsrc_m), .o_rd_addr_m(o_rd_addr_m),
    .o_pc4_m(o_pc4_m), .o_f3_m(o_f3_m)
  );

  typedef struct packed {
    logic [DW-1:0] res;
    logic [4:0]    rd;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Monitor: every write-back presented by EX/MEM is matched against the queue.
  always @(negedge i_clk) begin
    if (i_rst_n === 1'b1 && o_regwrite_m === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_writeback: actual rd=%0d result=0x%08h required no write-back",
                 o_rd_addr_m, o_alu_result_m);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("wb_result", o_alu_result_m, e.res);
        check("wb_rd", {27'd0, o_rd_addr_m}, {27'd0, e.rd});
      end
    end
  end

  task automatic drive_nop();
    i_rs1_data_e = '0; i_rs2_data_e = '0; i_immext_e = '0;
    i_pc_e = '0; i_pc4_e = '0; i_rd_addr_e = '0;
    i_aluctrl_e = 4'd0; i_alusrc_e = 2'b00;
    i_regwrite_e = 1'b0; i_memwrite_e = 1'b0; i_resultsrc_e = 2'b00; i_f3_e = 3'b000;
    i_md_valid_e = 1'b0; i_md_op_e = 3'd0;
    i_forward_m = '0; i_forward_w = '0; i_forward_a = 2'd0; i_forward_b = 2'd0;
    i_flush_e = 1'b0;
  endtask

  // Single-cycle ALU instruction; result is expected one cycle later.
  task automatic run_alu(input string name, input logic [3:0] ctrl, input logic [1:0] src,
                         input logic [1:0] fa, input logic [DW-1:0] rs1, input logic [DW-1:0] rs2,
                         input logic [DW-1:0] fm, input logic [AW-1:0] pc, input logic [DW-1:0] imm,
                         input logic [4:0] rd, input logic [DW-1:0] exp_res, input logic exp_zero);
    exp_t e;
    @(negedge i_clk);
    drive_nop();
    i_aluctrl_e = ctrl; i_alusrc_e = src; i_forward_a = fa; i_forward_m = fm;
    i_rs1_data_e = rs1; i_rs2_data_e = rs2; i_pc_e = pc; i_immext_e = imm;
    i_rd_addr_e = rd; i_regwrite_e = 1'b1;
    e.res = exp_res; e.rd = rd;
    sb_q.push_back(e);
    #1;
    check({name, "_stall"}, {31'd0, o_stall_e}, 32'd0);
    check({name, "_zero"}, {31'd0, o_zero_e}, {31'd0, exp_zero});
    @(posedge i_clk);
    #1 drive_nop();
  endtask

  // M-extension op; counts stall cycles, optionally perturbs the forwarding
  // inputs in the middle of BUSY.
  task automatic run_md(input string name, input logic [2:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [4:0] rd,
                        input logic [DW-1:0] exp_res, input bit perturb);
    exp_t e;
    int n;
    @(negedge i_clk);
    drive_nop();
    i_md_valid_e = 1'b1; i_md_op_e = op; i_rd_addr_e = rd; i_regwrite_e = 1'b1;
    i_rs2_data_e = b;
    if (perturb) begin
      i_forward_a = 2'd2; i_forward_m = a; i_rs1_data_e = ~a;
    end else begin
      i_rs1_data_e = a;
    end
    e.res = exp_res; e.rd = rd;
    sb_q.push_back(e);
    n = 0;
    #1;
    while (o_stall_e === 1'b1 && n < 200) begin
      n++;
      @(negedge i_clk);
      if (perturb && n == 5) begin
        i_forward_m = 32'h0000_0063; i_rs2_data_e = 32'h0000_0011; i_forward_a = 2'd0;
      end
      #1;
    end
    check({name, "_stall_cycles"}, n, 33);
    @(posedge i_clk);
    #1 drive_nop();
  endtask

  initial begin
    drive_nop();
    i_rst_n = 1'b1;
    #2 i_rst_n = 1'b0;
    #2;
    check("rst_stall", {31'd0, o_stall_e}, 32'd0);
    check("rst_regwrite", {31'd0, o_regwrite_m}, 32'd0);
    check("rst_alu_result", o_alu_result_m, 32'd0);
    check("rst_f3", {29'd0, o_f3_m}, 32'd2);
    check("rst_rd", {27'd0, o_rd_addr_m}, 32'd0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;

    // Single-cycle path: MEM forwarding, zero flag, PC-relative add.
    run_alu("add_fwd", 4'd0, 2'b00, 2'd2, 32'd100, 32'd3, 32'd5, 10'd0, 32'd0, 5'd1, 32'd8, 1'b0);
    run_alu("sub_eq", 4'd1, 2'b00, 2'd0, 32'h1234, 32'h1234, 32'd0, 10'd0, 32'd0, 5'd2, 32'd0, 1'b1);
    @(negedge i_clk);
    i_pc_e = 10'h100; i_immext_e = 32'h20;
    #1 check("pctarget", {22'd0, o_pctarget_e}, 32'h120);
    run_alu("auipc", 4'd0, 2'b11, 2'd0, 32'd0, 32'd0, 32'd0, 10'h100, 32'h20, 5'd3, 32'h120, 1'b0);

    // M ops, including sign, divide-by-zero and overflow corners.
    run_md("mul",    3'd0, 32'd7,         32'hFFFF_FFFD, 5'd4,  32'hFFFF_FFEB, 1'b0);
    run_md("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE, 1'b0);
    run_md("mulh",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'h0000_0000, 1'b0);
    run_md("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2,         5'd7,  32'hFFFF_FFFF, 1'b0);
    run_md("div_ovf",3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'h8000_0000, 1'b0);
    run_md("rem_ovf",3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'h0000_0000, 1'b0);
    run_md("divu_z", 3'd5, 32'd100,       32'd0,         5'd10, 32'hFFFF_FFFF, 1'b0);
    run_md("remu_z", 3'd7, 32'd100,       32'd0,         5'd11, 32'h0000_0064, 1'b0);
    run_md("div_neg",3'd4, 32'hFFFF_FFF9, 32'd2,         5'd12, 32'hFFFF_FFFD, 1'b0);
    run_md("rem_neg",3'd6, 32'hFFFF_FFF9, 32'd2,         5'd13, 32'hFFFF_FFFF, 1'b0);
    run_md("div_z",  3'd4, 32'd7,         32'd0,         5'd14, 32'hFFFF_FFFF, 1'b0);
    run_md("rem_z",  3'd6, 32'hFFFF_FFFB, 32'd0,         5'd15, 32'hFFFF_FFFB, 1'b0);
    run_md("divu",   3'd5, 32'hFFFF_FFF0, 32'd16,        5'd16, 32'h0FFF_FFFF, 1'b0);
    run_md("mul_fwd",3'd0, 32'd6,         32'd5,         5'd17, 32'd30,        1'b1);

    // Flush on the 10th BUSY cycle: stall drops next cycle, nothing written.
    @(negedge i_clk);
    drive_nop();
    i_md_valid_e = 1'b1; i_md_op_e = 3'd0; i_rs1_data_e = 32'd3; i_rs2_data_e = 32'd4;
    i_rd_addr_e = 5'd20; i_regwrite_e = 1'b1;
    #1 check("flush_t_stall", {31'd0, o_stall_e}, 32'd1);
    repeat (10) @(negedge i_clk);
    i_flush_e = 1'b1;
    #1 check("flush_busy_stall", {31'd0, o_stall_e}, 32'd1);
    @(negedge i_clk);
    drive_nop();
    #1 check("flush_next_stall", {31'd0, o_stall_e}, 32'd0);
    repeat (3) begin
      @(negedge i_clk);
      #1 check("flush_no_wb", {31'd0, o_regwrite_m}, 32'd0);
    end

    // Flush arriving together with an M op in IDLE: the op never starts.
    @(negedge i_clk);
    i_md_valid_e = 1'b1; i_md_op_e = 3'd4; i_rs1_data_e = 32'd9; i_rs2_data_e = 32'd3;
    i_rd_addr_e = 5'd21; i_regwrite_e = 1'b1; i_flush_e = 1'b1;
    #1 check("flush_idle_stall", {31'd0, o_stall_e}, 32'd0);
    @(negedge i_clk);
    drive_nop();
    #1 check("flush_idle_not_started", {31'd0, o_stall_e}, 32'd0);

    // Asynchronous reset in the middle of BUSY.
    @(negedge i_clk);
    i_md_valid_e = 1'b1; i_md_op_e = 3'd5; i_rs1_data_e = 32'd50; i_rs2_data_e = 32'd7;
    i_rd_addr_e = 5'd22; i_regwrite_e = 1'b1; i_f3_e = 3'b101;
    repeat (6) @(negedge i_clk);
    #3 i_rst_n = 1'b0;
    #1;
    check("rstmid_stall", {31'd0, o_stall_e}, 32'd0);
    check("rstmid_f3", {29'd0, o_f3_m}, 32'd2);
    check("rstmid_regwrite", {31'd0, o_regwrite_m}, 32'd0);
    drive_nop();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1 check("rstmid_idle", {31'd0, o_stall_e}, 32'd0);

    // Full operation after the mid-operation reset.
    run_md("mul_after_rst", 3'd0, 32'd12, 32'd12, 5'd23, 32'd144, 1'b0);

    repeat (4) @(negedge i_clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
